// File: rtl/ss_engine_multimode.sv
// Multi-topology state-space step engine: x <= A_m*x + B_m, y <= C*x, scaled and saturated to DAC codes.
// Latency: step accepted at cycle 0 -> done at cycle R*K+2, where R = max(K, N_OUT).
// Backpressure: none; a step while busy (including the done cycle) is dropped and flags overrun; en low stalls everything.
module ss_engine_multimode #(
    parameter int N_MAX  = 4,
    parameter int N_OUT  = 2,
    parameter int N_MODE = 4,
    parameter int PW     = 43,
    parameter int PF     = 32,
    parameter int SW     = 43,
    parameter int SF     = 32,
    parameter int DAC_W  = 14
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                step,
    input  logic [7:0]                          size,
    input  logic [$clog2(N_MODE)-1:0]           mode_sel,
    input  logic [N_MODE*N_MAX*N_MAX*PW-1:0]    A_flat,
    input  logic [N_MODE*N_MAX*PW-1:0]          B_flat,
    input  logic [N_OUT*N_MAX*PW-1:0]           C_flat,
    input  logic [31:0]                         dac_scale,
    output logic [N_OUT*SW-1:0]                 y_out,
    output logic [N_OUT*DAC_W-1:0]              dac_out,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun
);

    localparam int MW  = $clog2(N_MODE);
    localparam int KW  = $clog2(N_MAX + 1);
    localparam int IW  = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int AW  = SW + 4;          // accumulator width
    localparam int EW  = SW + 5;          // commit sum width, never wraps
    localparam int MPW = PW + SW;         // full-precision product width
    localparam int SPW = SW + 32;         // y * dac_scale product width
    localparam int DSH = SF + 31 - (DAC_W - 1);

    localparam logic [KW-1:0] NMAX_K = KW'(N_MAX);
    localparam logic [KW-1:0] NOUT_K = KW'(N_OUT);
    localparam logic [7:0]    NMAX_8 = 8'(N_MAX);

    localparam logic signed [EW-1:0]  SAT_MAX = $signed({{(EW-SW+1){1'b0}}, {(SW-1){1'b1}}});
    localparam logic signed [EW-1:0]  SAT_MIN = $signed({{(EW-SW+1){1'b1}}, {(SW-1){1'b0}}});
    localparam logic signed [SPW-1:0] D_MAX   = SPW'(2**(DAC_W-1) - 1);
    localparam logic signed [SPW-1:0] D_MIN   = SPW'(-(2**(DAC_W-1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_COMMIT,
        S_SCALE
    } state_t;

    // ------------------------------------------------------------------
    // Coefficient views of the flat parameter buses
    // ------------------------------------------------------------------
    logic signed [PW-1:0] a_arr [N_MODE][N_MAX][N_MAX];
    logic signed [PW-1:0] b_arr [N_MODE][N_MAX];
    logic signed [PW-1:0] c_arr [N_OUT][N_MAX];

    for (genvar m = 0; m < N_MODE; m++) begin : g_mode
        for (genvar r = 0; r < N_MAX; r++) begin : g_row
            assign b_arr[m][r] = B_flat[(m*N_MAX+r)*PW +: PW];
            for (genvar c = 0; c < N_MAX; c++) begin : g_col
                assign a_arr[m][r][c] = A_flat[((m*N_MAX+r)*N_MAX+c)*PW +: PW];
            end
        end
    end

    for (genvar r = 0; r < N_OUT; r++) begin : g_crow
        for (genvar c = 0; c < N_MAX; c++) begin : g_ccol
            assign c_arr[r][c] = C_flat[(r*N_MAX+c)*PW +: PW];
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [MW-1:0]          mode_q, mode_d;
    logic [KW-1:0]          r_q, r_d;
    logic [KW-1:0]          c_q, c_d;
    logic signed [SW-1:0]   x_q [N_MAX];
    logic signed [SW-1:0]   x_d [N_MAX];
    logic signed [AW-1:0]   acc_a_q [N_MAX];
    logic signed [AW-1:0]   acc_a_d [N_MAX];
    logic signed [AW-1:0]   acc_c_q [N_OUT];
    logic signed [AW-1:0]   acc_c_d [N_OUT];
    logic signed [SW-1:0]   y_q [N_OUT];
    logic signed [SW-1:0]   y_d [N_OUT];
    logic [DAC_W-1:0]       dac_q [N_OUT];
    logic [DAC_W-1:0]       dac_d [N_OUT];
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic signed [SW-1:0] sat_sw(input logic signed [EW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[SW-1:0];
        else if (v < SAT_MIN) return SAT_MIN[SW-1:0];
        else                  return v[SW-1:0];
    endfunction

    function automatic logic [DAC_W-1:0] dac_code(input logic signed [SW-1:0] y,
                                                  input logic signed [31:0] s);
        logic signed [SPW-1:0] prod;
        logic signed [SPW-1:0] t;
        prod = y * s;
        t    = prod >>> DSH;
        if (t > D_MAX)      return D_MAX[DAC_W-1:0];
        else if (t < D_MIN) return D_MIN[DAC_W-1:0];
        else                return t[DAC_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // MAC lane operands for the current (r, c) position
    // ------------------------------------------------------------------
    logic [KW-1:0]          r_max;
    logic [IW-1:0]          ri, ci;
    logic signed [SW-1:0]   x_c;
    logic signed [PW-1:0]   a_sel, c_sel;
    logic signed [MPW-1:0]  prod_a, prod_c;
    logic signed [AW-1:0]   term_a, term_c;

    // Select coefficients and form the truncated A and C products for this cycle.
    always_comb begin
        r_max = (k_q > NOUT_K) ? k_q : NOUT_K;
        ri    = r_q[IW-1:0];
        ci    = c_q[IW-1:0];
        // x only changes at commit, so it doubles as the step's snapshot.
        x_c   = x_q[ci];
        a_sel = a_arr[mode_q][ri][ci];
        c_sel = '0;
        for (int p = 0; p < N_OUT; p++) begin
            if (r_q == KW'(p)) c_sel = c_arr[p][ci];
        end
        prod_a = a_sel * x_c;
        prod_c = c_sel * x_c;
        term_a = AW'(prod_a >>> PF);
        term_c = AW'(prod_c >>> PF);
    end

    // ------------------------------------------------------------------
    // Next-state logic: accept, row/column sweep, commit, DAC scaling
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        mode_d    = mode_q;
        r_d       = r_q;
        c_d       = c_q;
        x_d       = x_q;
        acc_a_d   = acc_a_q;
        acc_c_d   = acc_c_q;
        y_d       = y_q;
        dac_d     = dac_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        // busy_q covers the done cycle too, so a step landing there is dropped.
        if (step && busy_q) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (step && !busy_q) begin
                    if (size == 8'd0)        k_d = KW'(1);
                    else if (size > NMAX_8)  k_d = NMAX_K;
                    else                     k_d = size[KW-1:0];
                    if (int'(mode_sel) >= N_MODE) mode_d = MW'(N_MODE - 1);
                    else                          mode_d = mode_sel;
                    r_d     = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end else begin
                    busy_d = 1'b0;
                end
            end

            S_CALC: begin
                if (r_q < k_q) acc_a_d[ri] = acc_a_q[ri] + term_a;
                for (int p = 0; p < N_OUT; p++) begin
                    if (r_q == KW'(p)) acc_c_d[p] = acc_c_q[p] + term_c;
                end
                if (c_q == k_q - KW'(1)) begin
                    c_d = '0;
                    if (r_q == r_max - KW'(1)) begin
                        r_d     = '0;
                        state_d = S_COMMIT;
                    end else begin
                        r_d = r_q + KW'(1);
                    end
                end else begin
                    c_d = c_q + KW'(1);
                end
            end

            S_COMMIT: begin
                // Saturating here keeps x from ever wrapping on the next step.
                for (int r = 0; r < N_MAX; r++) begin
                    if (r < int'(k_q))
                        x_d[r] = sat_sw(EW'(acc_a_q[r]) + EW'(b_arr[mode_q][r]));
                    else
                        x_d[r] = '0;
                    acc_a_d[r] = '0;
                end
                for (int p = 0; p < N_OUT; p++) begin
                    y_d[p]     = sat_sw(EW'(acc_c_q[p]));
                    acc_c_d[p] = '0;
                end
                state_d = S_SCALE;
            end

            S_SCALE: begin
                for (int p = 0; p < N_OUT; p++) begin
                    dac_d[p] = dac_code(y_q[p], $signed(dac_scale));
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // All engine state, frozen while en is low, aborted by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= KW'(1);
            mode_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_MAX; i++) begin
                x_q[i]     <= '0;
                acc_a_q[i] <= '0;
            end
            for (int p = 0; p < N_OUT; p++) begin
                acc_c_q[p] <= '0;
                y_q[p]     <= '0;
                dac_q[p]   <= '0;
            end
        end else if (en) begin
            state_q   <= state_d;
            k_q       <= k_d;
            mode_q    <= mode_d;
            r_q       <= r_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            acc_a_q   <= acc_a_d;
            acc_c_q   <= acc_c_d;
            y_q       <= y_d;
            dac_q     <= dac_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar p = 0; p < N_OUT; p++) begin : g_out
        assign y_out[p*SW +: SW]         = y_q[p];
        assign dac_out[p*DAC_W +: DAC_W] = dac_q[p];
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ss_engine_multimode.sv
// Scoreboard bench for ss_engine_multimode with hand-computed directed steps.
// Expected y/dac/done-cycle entries are queued at step acceptance and popped on done.
// Covers latency, mode latching, clamping, saturation, overrun, stall and reset abort.
module tb_ss_engine_multimode;

    localparam int N_MAX  = 4;
    localparam int N_OUT  = 2;
    localparam int N_MODE = 4;
    localparam int PW     = 43;
    localparam int SW     = 43;
    localparam int DAC_W  = 14;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             en;
    logic                             step;
    logic [7:0]                       size;
    logic [1:0]                       mode_sel;
    logic [31:0]                      dac_scale;
    logic [N_MODE*N_MAX*N_MAX*PW-1:0] A_flat;
    logic [N_MODE*N_MAX*PW-1:0]       B_flat;
    logic [N_OUT*N_MAX*PW-1:0]        C_flat;
    logic [N_OUT*SW-1:0]              y_out;
    logic [N_OUT*DAC_W-1:0]           dac_out;
    logic                             busy;
    logic                             done;
    logic                             overrun;

    logic [PW-1:0] a_t [N_MODE][N_MAX][N_MAX];
    logic [PW-1:0] b_t [N_MODE][N_MAX];
    logic [PW-1:0] c_t [N_OUT][N_MAX];

    for (genvar m = 0; m < N_MODE; m++) begin : g_m
        for (genvar r = 0; r < N_MAX; r++) begin : g_r
            assign B_flat[(m*N_MAX+r)*PW +: PW] = b_t[m][r];
            for (genvar c = 0; c < N_MAX; c++) begin : g_c
                assign A_flat[((m*N_MAX+r)*N_MAX+c)*PW +: PW] = a_t[m][r][c];
            end
        end
    end
    for (genvar r = 0; r < N_OUT; r++) begin : g_cr
        for (genvar c = 0; c < N_MAX; c++) begin : g_cc
            assign C_flat[(r*N_MAX+c)*PW +: PW] = c_t[r][c];
        end
    end

    ss_engine_multimode dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .step      (step),
        .size      (size),
        .mode_sel  (mode_sel),
        .A_flat    (A_flat),
        .B_flat    (B_flat),
        .C_flat    (C_flat),
        .dac_scale (dac_scale),
        .y_out     (y_out),
        .dac_out   (dac_out),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               id;
        int               done_cyc;
        logic [SW-1:0]    y0;
        logic [SW-1:0]    y1;
        logic [DAC_W-1:0] d0;
        logic [DAC_W-1:0] d1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Value in eighths, as a Q.32 word.
    function automatic logic [SW-1:0] q8(input int n);
        logic signed [SW-1:0] v;
        v = SW'(n);
        return v <<< 29;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=done_at_%0d expected=no_done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("step%0d_done_cycle", mon_e.id), 64'(cyc), 64'(mon_e.done_cyc));
                chk($sformatf("step%0d_y0", mon_e.id), 64'(y_out[0 +: SW]), 64'(mon_e.y0));
                chk($sformatf("step%0d_y1", mon_e.id), 64'(y_out[SW +: SW]), 64'(mon_e.y1));
                chk($sformatf("step%0d_dac0", mon_e.id), 64'(dac_out[0 +: DAC_W]), 64'(mon_e.d0));
                chk($sformatf("step%0d_dac1", mon_e.id), 64'(dac_out[DAC_W +: DAC_W]), 64'(mon_e.d1));
            end
        end
    end

    // Issue one step; returns at the first falling edge after acceptance.
    task automatic start_step(input int id, input logic [7:0] sz, input logic [1:0] md,
                              input int y0n, input int y1n,
                              input logic [DAC_W-1:0] d0, input logic [DAC_W-1:0] d1,
                              input int lat);
        exp_t e;
        @(negedge clk);
        size     = sz;
        mode_sel = md;
        step     = 1'b1;
        @(posedge clk);
        #1;
        e.id       = id;
        e.done_cyc = cyc + lat;
        e.y0       = q8(y0n);
        e.y1       = q8(y1n);
        e.d0       = d0;
        e.d1       = d1;
        sb.push_back(e);
        @(negedge clk);
        step = 1'b0;
        chk($sformatf("step%0d_busy", id), 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int id);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL step%0d_timeout actual=no_done expected=done", id);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        step      = 1'b0;
        size      = 8'd2;
        mode_sel  = 2'd0;
        dac_scale = 32'h3333_3333;
        a_t = '{default: '0};
        b_t = '{default: '0};
        c_t = '{default: '0};
        // Mode 0: A = 0.5*I, B = [1.0, 0, 0, 0]
        a_t[0][0][0] = q8(4);
        a_t[0][1][1] = q8(4);
        a_t[0][2][2] = q8(4);
        a_t[0][3][3] = q8(4);
        b_t[0][0]    = q8(8);
        // Mode 1: A = 0, B = [-2.0, 0]; mode 2: B = [10.0, 0]; mode 3: B = [-10.0, 0.25]
        b_t[1][0]    = q8(-16);
        b_t[2][0]    = q8(80);
        b_t[3][0]    = q8(-80);
        b_t[3][1]    = q8(2);
        // C = I on the first two states
        c_t[0][0]    = q8(8);
        c_t[1][1]    = q8(8);

        repeat (3) @(negedge clk);
        chk("reset_y_out", 64'(y_out), 64'd0);
        chk("reset_dac_out", 64'(dac_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Scale 0x33333333 (0.4): code = floor(v * 8192 * 0.4)
        start_step(1, 8'd2, 2'd0, 0, 0, 14'h0000, 14'h0000, 6);     // x -> [1.0, 0]
        wait_done(1);
        start_step(2, 8'd2, 2'd0, 8, 0, 14'h0CCC, 14'h0000, 6);     // x -> [1.5, 0]
        wait_done(2);
        start_step(3, 8'd2, 2'd1, 12, 0, 14'h1333, 14'h0000, 6);    // x -> [-2.0, 0]
        mode_sel = 2'd0;
        size     = 8'd4;
        wait_done(3);
        start_step(4, 8'd2, 2'd0, -16, 0, 14'h2666, 14'h0000, 6);   // x -> [0, 0]
        wait_done(4);

        // Scale 0x1999999A (0.2): code = floor(v * 1638.4)
        dac_scale = 32'h1999_999A;
        start_step(5, 8'd2, 2'd2, 0, 0, 14'h0000, 14'h0000, 6);     // x -> [10, 0]
        wait_done(5);
        start_step(6, 8'd2, 2'd2, 80, 0, 14'h1FFF, 14'h0000, 6);    // positive DAC clamp
        wait_done(6);
        start_step(7, 8'd2, 2'd3, 80, 0, 14'h1FFF, 14'h0000, 6);    // x -> [-10, 0.25]
        wait_done(7);
        start_step(8, 8'd2, 2'd0, -80, 2, 14'h2000, 14'h0199, 6);   // negative clamp; x -> [-4, 0.125]
        wait_done(8);
        start_step(9, 8'd0, 2'd0, -32, 0, 14'h2666, 14'h0000, 4);   // K=1 masks x1; x -> [-1, 0, 0, 0]
        wait_done(9);
        start_step(10, 8'd9, 2'd0, -8, 0, 14'h3999, 14'h0000, 18);  // K=4; x -> [0.5, 0, 0, 0]
        wait_done(10);

        // Step request while busy
        chk("overrun_before", 64'(overrun), 64'd0);
        start_step(11, 8'd2, 2'd0, 4, 0, 14'h0333, 14'h0000, 6);    // x -> [1.25, 0]
        repeat (2) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("overrun_set", 64'(overrun), 64'd1);
        wait_done(11);
        chk("overrun_sticky", 64'(overrun), 64'd1);

        // Five-cycle enable stall in the middle of CALC
        start_step(12, 8'd2, 2'd0, 10, 0, 14'h0800, 14'h0000, 11);  // x -> [1.625, 0]
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_busy", 64'(busy), 64'd1);
        en = 1'b1;
        wait_done(12);

        // Reset in the middle of CALC aborts the step
        start_step(13, 8'd2, 2'd0, 0, 0, 14'h0000, 14'h0000, 6);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_y_out", 64'(y_out), 64'd0);
        chk("abort_dac_out", 64'(dac_out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_step(14, 8'd2, 2'd0, 0, 0, 14'h0000, 14'h0000, 6);    // x -> [1.0, 0]
        wait_done(14);
        start_step(15, 8'd2, 2'd0, 8, 0, 14'h0666, 14'h0000, 6);
        wait_done(15);
        chk("final_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
